// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch counter datapath.
//   DIGIT_W   : width of one counter digit
//   state_e   : run-control FSM encoding (IDLE/RUN/STOP)
//   digit_max : pulls digit i's terminal value out of a packed DIGIT_MAX word
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  function automatic logic [DIGIT_W-1:0] digit_max(input logic [31:0] dm, input int i);
    return dm[DIGIT_W*i +: DIGIT_W];
  endfunction

endpackage

// File: rtl/stopwatch_counter_digit.sv
// One modulo digit of the stopwatch chain.
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous zero
//   en         : increment this cycle
//   max        : terminal value; the digit wraps from max to 0
//   q          : current digit value
//   at_max     : q equals max (feeds the carry chain)
module digit_counter
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic [DIGIT_W-1:0] max,
  output logic [DIGIT_W-1:0] q,
  output logic               at_max
);

  localparam logic [DIGIT_W-1:0] ONE = 1;

  logic [DIGIT_W-1:0] q_q, q_d;

  assign at_max = (q_q == max);
  assign q      = q_q;

  always_comb begin
    q_d = q_q;
    if (clr)       q_d = '0;
    else if (en)   q_d = at_max ? '0 : q_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Multi-digit stopwatch counter with run/stop/clear control.
//   clk, reset : clock, synchronous active-high reset
//   tick       : count enable pulse from the prescaler
//   start_stop : toggles run state (IDLE->RUN, RUN->STOP, STOP->RUN)
//   clear      : zero the count, return to IDLE
//   lap        : lap hold toggle (only with STOPWATCH_LAP_EN)
//   count      : live count, digit 0 in LSBs
//   disp       : count, or lap snapshot while hold is active
//   running    : registered state==RUN
//   overflow   : one-cycle pulse on the full-chain terminal increment
// Optional feature macro: STOPWATCH_LAP_EN (lap snapshot/hold).
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int          NUM_DIGITS = 4,
  parameter logic [31:0] DIGIT_MAX  = 32'h0000_5959,
  parameter int          WRAP       = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          start_stop,
  input  logic                          clear,
  input  logic                          lap,
  output logic [DIGIT_W*NUM_DIGITS-1:0] count,
  output logic [DIGIT_W*NUM_DIGITS-1:0] disp,
  output logic                          running,
  output logic                          overflow
);

  localparam int CW       = DIGIT_W * NUM_DIGITS;
  localparam bit SATURATE = (WRAP == 0);

  state_e            state_q, state_d;
  logic              sat_q, sat_d;
  logic              running_q, running_d;
  logic              overflow_q, overflow_d;
  logic              cnt_en, terminal;
  logic [NUM_DIGITS:0]   carry;
  logic [NUM_DIGITS-1:0] at_max, dig_en;
  logic [CW-1:0]     count_w;

  // sat_q blocks all counting once a non-wrapping chain has hit terminal,
  // even after start_stop puts the FSM back in RUN; only clear/reset lift it.
  assign cnt_en   = tick & (state_q == RUN) & ~clear & ~sat_q;
  assign carry[0] = cnt_en;
  assign terminal = carry[NUM_DIGITS];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign carry[i+1] = carry[i] & at_max[i];
    // A saturating chain must not wrap its digits on the terminal tick.
    assign dig_en[i]  = carry[i] & ~(SATURATE & terminal);
    digit_counter u_digit (
      .clk    (clk),
      .reset  (reset),
      .clr    (clear),
      .en     (dig_en[i]),
      .max    (digit_max(DIGIT_MAX, i)),
      .q      (count_w[DIGIT_W*i +: DIGIT_W]),
      .at_max (at_max[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    sat_d      = sat_q;
    overflow_d = terminal;
    if (clear) begin
      state_d = IDLE;
      sat_d   = 1'b0;
    end else begin
      if (start_stop) begin
        case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = STOP;
          STOP:    state_d = RUN;
          default: state_d = IDLE;
        endcase
      end else if (terminal && SATURATE) begin
        state_d = STOP;
      end
      if (terminal && SATURATE) sat_d = 1'b1;
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sat_q      <= 1'b0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sat_q      <= sat_d;
      running_q  <= running_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_w;
  assign running  = running_q;
  assign overflow = overflow_q;

`ifdef STOPWATCH_LAP_EN
  logic          hold_q, hold_d;
  logic [CW-1:0] snap_q, snap_d;

  always_comb begin
    hold_d = hold_q;
    snap_d = snap_q;
    if (clear) begin
      hold_d = 1'b0;
      snap_d = '0;
    end else if (lap) begin
      if (hold_q) begin
        hold_d = 1'b0;
      end else if (state_q == RUN) begin
        hold_d = 1'b1;
        snap_d = count_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= 1'b0;
      snap_q <= '0;
    end else begin
      hold_q <= hold_d;
      snap_q <= snap_d;
    end
  end

  assign disp = hold_q ? snap_q : count_w;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp       = count_w;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

  logic clk = 1'b0;
  logic reset = 1'b0, tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [15:0] cnt0, disp0, cnt1, disp1;
  logic        run0, ovf0, run1, ovf1;

  always #5 clk = ~clk;

  // u0 wraps, u1 saturates; both see identical stimulus.
  stopwatch_counter #(.NUM_DIGITS(4), .DIGIT_MAX(32'h0000_5959), .WRAP(1)) u0 (
    .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .clear(clear),
    .lap(lap), .count(cnt0), .disp(disp0), .running(run0), .overflow(ovf0));
  stopwatch_counter #(.NUM_DIGITS(4), .DIGIT_MAX(32'h0000_5959), .WRAP(0)) u1 (
    .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .clear(clear),
    .lap(lap), .count(cnt1), .disp(disp1), .running(run1), .overflow(ovf1));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0][15:0] cnt;
    logic [1:0][15:0] disp;
    logic [1:0]       run;
    logic [1:0]       ovf;
  } exp_t;
  exp_t sb[$];

  // Reference model: total elapsed count as an integer, mm:ss encoded on output.
  localparam int FULL = 3600;
  int m_n[2], m_st[2], m_snap[2];
  bit m_sat[2], m_hold[2], m_ovf[2];

  function automatic logic [15:0] enc(input int n);
    logic [15:0] r;
    int v;
    v = n;
    r[3:0]   = 4'(v % 10); v = v / 10;
    r[7:4]   = 4'(v % 6);  v = v / 6;
    r[11:8]  = 4'(v % 10); v = v / 10;
    r[15:12] = 4'(v % 6);
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 25) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model(input bit r, s, c, t, l);
    for (int w = 0; w < 2; w++) begin
      if (r || c) begin
        m_n[w] = 0; m_st[w] = 0; m_sat[w] = 0; m_hold[w] = 0; m_snap[w] = 0; m_ovf[w] = 0;
      end else begin
        m_ovf[w] = 0;
        if (l) begin
          if (m_hold[w]) m_hold[w] = 0;
          else if (m_st[w] == 1) begin m_hold[w] = 1; m_snap[w] = m_n[w]; end
        end
        if (t && m_st[w] == 1 && !m_sat[w]) begin
          if (m_n[w] == FULL - 1) begin
            m_ovf[w] = 1;
            if (w == 0) m_n[w] = 0;
            else        m_sat[w] = 1;
          end else m_n[w]++;
        end
        if (s) m_st[w] = (m_st[w] == 1) ? 2 : 1;
        else if (m_ovf[w] && w == 1) m_st[w] = 2;
      end
    end
  endtask

  task automatic step(input bit r, s, c, t, l);
    exp_t e, g;
    reset = r; start_stop = s; clear = c; tick = t; lap = l;
    model(r, s, c, t, l);
    for (int w = 0; w < 2; w++) begin
      e.cnt[w] = enc(m_n[w]);
`ifdef STOPWATCH_LAP_EN
      e.disp[w] = m_hold[w] ? enc(m_snap[w]) : enc(m_n[w]);
`else
      e.disp[w] = enc(m_n[w]);
`endif
      e.run[w] = (m_st[w] == 1);
      e.ovf[w] = m_ovf[w];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("sb_cnt0", cnt0, g.cnt[0]);   chk("sb_cnt1", cnt1, g.cnt[1]);
    chk("sb_disp0", disp0, g.disp[0]); chk("sb_disp1", disp1, g.disp[1]);
    chk("sb_run0", {15'd0, run0}, {15'd0, g.run[0]});
    chk("sb_run1", {15'd0, run1}, {15'd0, g.run[1]});
    chk("sb_ovf0", {15'd0, ovf0}, {15'd0, g.ovf[0]});
    chk("sb_ovf1", {15'd0, ovf1}, {15'd0, g.ovf[1]});
    reset = 0; start_stop = 0; clear = 0; tick = 0; lap = 0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 1, 0);
  endtask

  // Table: inputs held for reps cycles, then u0 outputs compared to constants.
  typedef struct {
    string name;
    bit r, s, c, t, l;
    int reps;
    logic [15:0] cnt;
    bit run, ovf;
  } vec_t;
  vec_t tbl[$];

  initial begin
    tbl.push_back('{"reset",       1,0,0,0,0,  1, 16'h0000, 0, 0});
    tbl.push_back('{"start",       0,1,0,0,0,  1, 16'h0000, 1, 0});
    tbl.push_back('{"ten_ticks",   0,0,0,1,0, 10, 16'h0010, 1, 0});
    tbl.push_back('{"clear_a",     0,0,1,0,0,  1, 16'h0000, 0, 0});
    tbl.push_back('{"start_a",     0,1,0,0,0,  1, 16'h0000, 1, 0});
    tbl.push_back('{"to_0009",     0,0,0,1,0,  9, 16'h0009, 1, 0});
    tbl.push_back('{"tick_ss",     0,1,0,1,0,  1, 16'h0010, 0, 0});
    tbl.push_back('{"tick_stop",   0,0,0,1,0,  1, 16'h0010, 0, 0});
    tbl.push_back('{"ss_idle_tk",  0,0,1,0,0,  1, 16'h0000, 0, 0});
    tbl.push_back('{"idle_tk_ss",  0,1,0,1,0,  1, 16'h0000, 1, 0});
    tbl.push_back('{"to_0123",     0,0,0,1,0, 83, 16'h0123, 1, 0});
    tbl.push_back('{"clr_tk_ss",   0,1,1,1,0,  1, 16'h0000, 0, 0});
    tbl.push_back('{"restart",     0,1,0,0,0,  1, 16'h0000, 1, 0});
    tbl.push_back('{"to_0005",     0,0,0,1,0,  5, 16'h0005, 1, 0});
    tbl.push_back('{"reset_mid",   1,0,0,1,0,  1, 16'h0000, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].reps; k++)
        step(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].t, tbl[i].l);
      chk({tbl[i].name, "_cnt"}, cnt0, tbl[i].cnt);
      chk({tbl[i].name, "_run"}, {15'd0, run0}, {15'd0, tbl[i].run});
      chk({tbl[i].name, "_ovf"}, {15'd0, ovf0}, {15'd0, tbl[i].ovf});
    end

    // Terminal behaviour: 59:59 then one more tick on both builds.
    step(0, 1, 0, 0, 0);
    ticks(3599);
    chk("pre_term0", cnt0, 16'h5959);
    chk("pre_term1", cnt1, 16'h5959);
    step(0, 0, 0, 1, 0);
    chk("wrap_cnt", cnt0, 16'h0000);
    chk("wrap_ovf", {15'd0, ovf0}, 16'd1);
    chk("wrap_run", {15'd0, run0}, 16'd1);
    chk("sat_cnt", cnt1, 16'h5959);
    chk("sat_ovf", {15'd0, ovf1}, 16'd1);
    chk("sat_run", {15'd0, run1}, 16'd0);
    step(0, 0, 0, 0, 0);
    chk("wrap_ovf_off", {15'd0, ovf0}, 16'd0);
    chk("sat_ovf_off", {15'd0, ovf1}, 16'd0);
    step(0, 1, 0, 0, 0);
    chk("sat_rerun", {15'd0, run1}, 16'd1);
    ticks(5);
    chk("sat_hold", cnt1, 16'h5959);
    chk("sat_no_ovf", {15'd0, ovf1}, 16'd0);
    step(0, 0, 1, 0, 0);
    chk("sat_clear", cnt1, 16'h0000);

    // Lap snapshot/hold.
    step(0, 1, 0, 0, 0);
    ticks(42);
    step(0, 0, 0, 0, 1);
    ticks(7);
    chk("lap_cnt", cnt0, 16'h0049);
`ifdef STOPWATCH_LAP_EN
    chk("lap_disp", disp0, 16'h0042);
`else
    chk("lap_disp", disp0, 16'h0049);
`endif
    step(0, 0, 0, 0, 1);
    chk("lap_release", disp0, 16'h0049);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("lap_in_stop", disp0, cnt0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    ticks(3);
    step(0, 0, 1, 0, 1);
    chk("lap_clear", disp0, 16'h0000);
    ticks(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Parametrised multi-digit modulo counter chain with run/stop/clear control for the stopwatch datapath.
- Each digit is a 4-bit modulo counter with its own terminal value. Digits cascade by carry.
- Sits between the tick prescaler (provides the `tick` enable pulse) and the seven-segment display mux (consumes `disp`).

Parameters:
- NUM_DIGITS, 4, number of cascaded 4-bit digits (1..8).
- DIGIT_MAX, 32'h0000_5959, packed per-digit terminal values. Digit i uses bits [4i+3:4i]. Each value is 1..15. Default gives mm:ss.
- WRAP, 1, behaviour at full-chain terminal: 1 = roll over to zero; 0 = saturate and stop.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  count enable pulse, one clk wide.
- start_stop  in  1  toggle-run pulse, one clk wide.
- clear  in  1  zero-count pulse, one clk wide.
- lap  in  1  lap toggle pulse (used only with the lap feature).
- count  out  4*NUM_DIGITS  live count, digit 0 in LSBs.
- disp  out  4*NUM_DIGITS  display value: live count, or lap snapshot.
- running  out  1  high while in RUN.
- overflow  out  1  one-cycle pulse on full-chain terminal increment.

Behaviour:
- Reset (synchronous, active-high):
  - count=0, disp=0, running=0, overflow=0.
  - State goes to IDLE; lap hold is cleared.
- State machine:
  - States are IDLE, RUN, STOP.
  - start_stop moves IDLE->RUN, RUN->STOP and STOP->RUN.
  - clear in any state goes to IDLE and sets count=0.
- Priority within one cycle: reset > clear > start_stop > tick.
- Counting:
  - The count advances only when tick=1 and the current state is RUN. The new value is visible the cycle after the tick (1-cycle latency).
  - Digit i increments when tick is qualified and every digit j<i equals its DIGIT_MAX.
  - A digit at its DIGIT_MAX that increments wraps to 0. Arithmetic is 4-bit unsigned; no digit ever exceeds its max.
- Simultaneous events:
  - tick + start_stop in RUN: the tick is counted and the state goes to STOP.
  - tick + start_stop in IDLE/STOP: the tick is not counted.
  - tick + clear: count=0; the tick is discarded.
- Terminal (all digits at max, qualified tick):
  - WRAP=1: count becomes 0, overflow=1 for one cycle, state stays RUN.
  - WRAP=0: count holds at max, overflow=1 for one cycle, state goes to STOP. Later ticks are ignored until clear.
  - If WRAP=0 and start_stop arrives while saturated in STOP: the state goes to RUN, but the count stays at max. No further overflow pulse is issued.
- Outputs:
  - running is a registered decode of state==RUN.
  - overflow is registered.
  - disp equals count unless the lap hold is active.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - A lap pulse while RUN with hold inactive captures the current count into the snapshot register and sets hold. disp shows the snapshot from the next cycle; count continues internally.
  - A lap pulse while hold is active releases hold; disp follows count from the next cycle.
  - A lap pulse in IDLE/STOP with hold inactive is ignored.
  - clear or reset releases hold and zeroes the snapshot.
  - lap + clear in the same cycle: clear wins.
- Undefined: the lap input is ignored, there is no snapshot register, and disp is tied to count.

Decomposition:
- Package stopwatch_pkg:
  - DIGIT_W=4.
  - State encoding constants: IDLE=2'd0, RUN=2'd1, STOP=2'd2.
  - Helper function that extracts digit i from a packed DIGIT_MAX.
- Sub-module digit_counter:
  - Inputs: clk, reset, clr, en, max[3:0].
  - Outputs: q[3:0], at_max.
  - Increments on en, wraps at max, zeroes on clr/reset.
- Top-level responsibilities:
  - Generate-instantiates NUM_DIGITS of digit_counter.
  - Forms the AND-chain carry.
  - Holds the FSM, the saturation logic and the lap logic.

Test Plan:
1. Reset, start_stop, 10 ticks (defaults) -> count=16'h0010, running=1, overflow=0.
2. Preload 59:59 via 3599 ticks, then 1 more tick with WRAP=1 -> count=16'h0000, overflow high exactly one cycle, running=1.
3. Same sequence with WRAP=0 -> count stays 16'h5959, overflow one-cycle pulse, running=0; a further start_stop + 5 ticks -> count still 16'h5959.
4. In RUN at 16'h0009, assert tick+start_stop in the same cycle -> count=16'h0010, running=0; a next tick -> no change.
5. In RUN at 16'h0123, assert clear+tick+start_stop together -> count=0, running=0, state IDLE; an asserted reset mid-run -> all outputs 0 next cycle.
6. With STOPWATCH_LAP_EN: lap at 16'h0042, then 7 ticks -> disp=16'h0042, count=16'h0049. A second lap -> disp=16'h0049. Without the macro the same stimulus -> disp tracks count every cycle.
